// File: rtl/ehgu_fifo_arb.sv
// ehgu_fifo_arb: round-robin burst scheduler sharing one FIFO write port, with occupancy credit tracking.
// Optional EHGU_FIFO_ARB_PRIO_EN: requester 0 gets fixed priority; 1..NREQ-1 rotate among themselves.
module ehgu_fifo_arb #(
    parameter int NREQ = 4,
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int MAX_BURST = 4,
    localparam int SW = $clog2(NREQ),
    localparam int LW = $clog2(DEPTH) + 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ-1:0]       req_last,
    input  logic [NREQ*WIDTH-1:0] req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic                  fifo_wr_en,
    output logic [WIDTH-1:0]      fifo_wr_data,
    output logic [SW-1:0]         fifo_wr_src,
    input  logic                  fifo_rd_en,
    output logic [LW-1:0]         level,
    output logic                  full,
    output logic                  empty,
    output logic [SW-1:0]         grant_id
);
    localparam logic [0:0] IDLE = 1'b0, GRANT = 1'b1;
    logic [0:0] state;
    logic [SW-1:0] rr_ptr, pick, idx, next_ptr;
    logic [4:0] beat_cnt;
    logic hit, accept, pop, burst_end;
    logic [LW-1:0] level_next;
    always_comb begin
        hit = 1'b0;
        pick = '0;
        idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            idx = SW'((int'(rr_ptr) + i) % NREQ);
`ifdef EHGU_FIFO_ARB_PRIO_EN
            if (!hit && idx != '0 && req_valid[idx]) begin
`else
            if (!hit && req_valid[idx]) begin
`endif
                hit = 1'b1;
                pick = idx;
            end
        end
`ifdef EHGU_FIFO_ARB_PRIO_EN
        if (req_valid[0]) begin
            hit = 1'b1;
            pick = '0;
        end
`endif
    end
    assign req_ready = (state == GRANT && !full) ? {{(NREQ-1){1'b0}}, 1'b1} << grant_id : '0;
    assign accept = state == GRANT && !full && req_valid[grant_id];
    assign pop = fifo_rd_en && !empty;
    assign burst_end = accept && (req_last[grant_id] || beat_cnt == 5'(MAX_BURST - 1));
    assign level_next = level + LW'(accept) - LW'(pop);
    assign next_ptr = (grant_id == SW'(NREQ - 1)) ? '0 : grant_id + SW'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rr_ptr <= '0;
            grant_id <= '0;
            beat_cnt <= '0;
            level <= '0;
            full <= 1'b0;
            empty <= 1'b1;
            fifo_wr_en <= 1'b0;
            fifo_wr_data <= '0;
            fifo_wr_src <= '0;
        end else begin
            level <= level_next;
            full <= level_next == LW'(DEPTH);
            empty <= level_next == '0;
            fifo_wr_en <= accept;
            if (accept) begin
                fifo_wr_data <= req_data[int'(grant_id)*WIDTH +: WIDTH];
                fifo_wr_src <= grant_id;
                beat_cnt <= beat_cnt + 5'd1;
            end
            if (state == IDLE && hit) begin
                state <= GRANT;
                grant_id <= pick;
                beat_cnt <= '0;
            end else if (burst_end) begin
                state <= IDLE;
`ifdef EHGU_FIFO_ARB_PRIO_EN
                if (grant_id != '0) rr_ptr <= next_ptr;
`else
                rr_ptr <= next_ptr;
`endif
            end
        end
    end
endmodule

// File: tb/tb_ehgu_fifo_arb.sv
// tb_ehgu_fifo_arb: directed scenarios checked every cycle against a queue-driven behavioural model.
module tb_ehgu_fifo_arb;
    localparam int NREQ = 4, WIDTH = 8, DEPTH = 32, MAX_BURST = 4;
    localparam int SW = $clog2(NREQ), LW = $clog2(DEPTH) + 1;
    logic clk = 1'b0, rst, fifo_rd_en;
    logic [NREQ-1:0] req_valid, req_last, req_ready;
    logic [NREQ*WIDTH-1:0] req_data;
    logic fifo_wr_en, full, empty;
    logic [WIDTH-1:0] fifo_wr_data;
    logic [SW-1:0] fifo_wr_src, grant_id;
    logic [LW-1:0] level;

    ehgu_fifo_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
        .req_ready(req_ready), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
        .fifo_wr_src(fifo_wr_src), .fifo_rd_en(fifo_rd_en), .level(level), .full(full),
        .empty(empty), .grant_id(grant_id));

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0;
    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Requester beat queues: MSB is the last flag.
    logic [WIDTH:0] q [NREQ][$];
    logic [NREQ-1:0] acc_s = '0;
    int acc_cnt [NREQ];
    logic [WIDTH-1:0] wq_d[$];
    logic [SW-1:0] wq_s[$];
    bit chk_en = 0;

    // Model state: whether a requester owns the port, which one, beats taken, rotation start, occupancy.
    int m_busy = 0, m_gid = 0, m_beats = 0, m_ptr = 0, m_level = 0;
    bit m_wr = 0;
    int m_wdata = 0, m_wsrc = 0;
    int glog[$];

    always @(posedge clk) begin
        int found, j;
        bit acc, pp;
        if (rst) begin
            m_busy = 0; m_gid = 0; m_beats = 0; m_ptr = 0; m_level = 0; m_wr = 0;
        end else begin
            acc = m_busy != 0 && req_valid[m_gid] && m_level < DEPTH;
            pp = fifo_rd_en && m_level > 0;
            m_wr = acc;
            if (acc) begin
                m_wdata = int'(req_data[m_gid*WIDTH +: WIDTH]);
                m_wsrc = m_gid;
            end
            m_level = m_level + int'(acc) - int'(pp);
            if (m_busy != 0) begin
                if (acc) begin
                    m_beats++;
                    if (req_last[m_gid] || m_beats == MAX_BURST) begin
                        m_busy = 0;
`ifdef EHGU_FIFO_ARB_PRIO_EN
                        if (m_gid != 0) m_ptr = (m_gid + 1) % NREQ;
`else
                        m_ptr = (m_gid + 1) % NREQ;
`endif
                    end
                end
            end else begin
                found = -1;
`ifdef EHGU_FIFO_ARB_PRIO_EN
                if (req_valid[0]) found = 0;
`endif
                for (int k = 0; k < NREQ; k++) begin
                    j = (m_ptr + k) % NREQ;
`ifdef EHGU_FIFO_ARB_PRIO_EN
                    if (found < 0 && j != 0 && req_valid[j]) found = j;
`else
                    if (found < 0 && req_valid[j]) found = j;
`endif
                end
                if (found >= 0) begin
                    m_busy = 1; m_gid = found; m_beats = 0;
                    glog.push_back(found);
                end
            end
        end
    end

    always @(negedge clk) begin
        acc_s = req_valid & req_ready;
        if (chk_en) begin
            chk("req_ready", 32'(req_ready), (m_busy != 0 && m_level < DEPTH) ? 32'(1) << m_gid : 32'd0);
            chk("fifo_wr_en", 32'(fifo_wr_en), 32'(m_wr));
            if (m_wr) begin
                chk("fifo_wr_data", 32'(fifo_wr_data), m_wdata);
                chk("fifo_wr_src", 32'(fifo_wr_src), m_wsrc);
            end
            chk("level", 32'(level), m_level);
            chk("full", 32'(full), 32'(m_level == DEPTH));
            chk("empty", 32'(empty), 32'(m_level == 0));
            chk("grant_id", 32'(grant_id), m_gid);
        end
        if (fifo_wr_en === 1'b1) begin
            wq_d.push_back(fifo_wr_data);
            wq_s.push_back(fifo_wr_src);
        end
    end

    // Requesters present their queue heads and retire a beat once it was seen accepted.
    initial begin
        req_valid = '0; req_last = '0; req_data = '0;
        for (int i = 0; i < NREQ; i++) acc_cnt[i] = 0;
        forever begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc_s[i] && q[i].size() > 0) begin
                    void'(q[i].pop_front());
                    acc_cnt[i]++;
                end
                req_valid[i] = q[i].size() > 0;
                req_last[i] = q[i].size() > 0 ? q[i][0][WIDTH] : 1'b0;
                req_data[i*WIDTH +: WIDTH] = q[i].size() > 0 ? q[i][0][WIDTH-1:0] : '0;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic push(input int r, input int d, input bit l);
        q[r].push_back({l, WIDTH'(d)});
    endtask

    task automatic clear_q();
        for (int i = 0; i < NREQ; i++) q[i].delete();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fifo_rd_en = 1'b0;
        clear_q();
        cyc(2);
        rst = 1'b0;
        wq_d.delete();
        wq_s.delete();
        glog.delete();
    endtask

    function automatic bit all_empty();
        for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction

    int base, maxlvl, k;
`ifdef EHGU_FIFO_ARB_PRIO_EN
    int exp_rr[6] = '{0, 0, 1, 2, 3, 1};
    int exp_src3[12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int exp_g3[5] = '{0, 0, 1, 1, 1};
    int exp_g6[6] = '{0, 0, 0, 2, 2, 2};
`else
    int exp_rr[6] = '{0, 1, 2, 3, 0, 1};
    int exp_src3[12] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 1, 1, 1};
    int exp_g3[5] = '{0, 1, 0, 1, 1};
    int exp_g6[6] = '{0, 2, 0, 2, 0, 2};
`endif

    initial begin
        rst = 1'b1;
        fifo_rd_en = 1'b0;
        cyc(1);
        chk_en = 1;
        do_reset();
        chk("rst_level", 32'(level), 0);
        chk("rst_empty", 32'(empty), 1);
        chk("rst_full", 32'(full), 0);
        chk("rst_wr_en", 32'(fifo_wr_en), 0);
        chk("rst_wr_data", 32'(fifo_wr_data), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant_id), 0);

        // Single requester, three-beat burst
        push(2, 'h11, 0); push(2, 'h22, 0); push(2, 'h33, 1);
        for (k = 0; k < 20 && q[2].size() != 0; k++) cyc(1);
        cyc(2);
        chk("t1_level", 32'(level), 3);
        chk("t1_empty", 32'(empty), 0);
        chk("t1_nwr", wq_d.size(), 3);
        chk("t1_d0", 32'(wq_d[0]), 'h11);
        chk("t1_d1", 32'(wq_d[1]), 'h22);
        chk("t1_d2", 32'(wq_d[2]), 'h33);
        chk("t1_src", 32'(wq_s[2]), 2);
        chk("t1_ptr", m_ptr, 3);
        chk("t1_ngrant", glog.size(), 1);
        chk("t1_grant", glog[0], 2);

        // Round-robin among four single-beat bursts, consumer popping every cycle
        do_reset();
        fifo_rd_en = 1'b1;
        for (int r = 0; r < NREQ; r++) for (int b = 0; b < 2; b++) push(r, 'h40 + r * 2 + b, 1);
        maxlvl = 0;
        for (k = 0; k < 40 && !all_empty(); k++) begin
            cyc(1);
            if (int'(level) > maxlvl) maxlvl = int'(level);
        end
        cyc(2);
        fifo_rd_en = 1'b0;
        chk("t2_done", 32'(all_empty()), 1);
        chk("t2_ngrant", glog.size(), 8);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_order%0d", i), glog[i], exp_rr[i]);
        chk("t2_maxlvl", maxlvl, 1);
        chk("t2_level", 32'(level), 0);

        // MAX_BURST cut: requester 1 never signals last
        do_reset();
        fifo_rd_en = 1'b1;
        for (int b = 0; b < 10; b++) push(1, 'h80 + b, 0);
        push(0, 'h60, 1); push(0, 'h61, 1);
        for (k = 0; k < 80 && wq_s.size() < 12; k++) cyc(1);
        fifo_rd_en = 1'b0;
        chk("t3_nwr", wq_s.size(), 12);
        for (int i = 0; i < 12; i++) chk($sformatf("t3_src%0d", i), 32'(wq_s[i]), exp_src3[i]);
        for (int i = 0; i < 5; i++) chk($sformatf("t3_grant%0d", i), glog[i], exp_g3[i]);

        // Full boundary
        do_reset();
        for (int b = 0; b < 33; b++) push(0, b, 1);
        for (k = 0; k < 100 && int'(level) != DEPTH; k++) cyc(1);
        cyc(3);
        chk("t4_full", 32'(full), 1);
        chk("t4_ready_full", 32'(req_ready), 0);
        chk("t4_level_full", 32'(level), 32);
        fifo_rd_en = 1'b1;
        cyc(1);
        fifo_rd_en = 1'b0;
        chk("t4_level_pop", 32'(level), 31);
        chk("t4_ready_pop", 32'(req_ready), 1);
        cyc(1);
        chk("t4_level_refill", 32'(level), 32);
        chk("t4_full_refill", 32'(full), 1);
        push(0, 'hA5, 1);
        cyc(3);
        fifo_rd_en = 1'b1;
        cyc(2);
        fifo_rd_en = 1'b0;
        chk("t4_level_both", 32'(level), 31);
        cyc(2);
        chk("t4_level_hold", 32'(level), 31);
        chk("t4_full_clear", 32'(full), 0);
        chk("t4_drained", q[0].size(), 0);

        // Pops while empty are ignored
        do_reset();
        fifo_rd_en = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("t5_level", 32'(level), 0);
            chk("t5_empty", 32'(empty), 1);
        end
        fifo_rd_en = 1'b0;

        // Reset in the middle of a burst
        do_reset();
        base = acc_cnt[3];
        for (int b = 0; b < 4; b++) push(3, 'hC0 + b, b == 3);
        for (k = 0; k < 20 && acc_cnt[3] - base < 2; k++) cyc(1);
        chk("t6_midburst", acc_cnt[3] - base, 2);
        rst = 1'b1;
        clear_q();
        cyc(1);
        rst = 1'b0;
        chk("t6_level", 32'(level), 0);
        chk("t6_wr_en", 32'(fifo_wr_en), 0);
        chk("t6_empty", 32'(empty), 1);
        chk("t6_ready", 32'(req_ready), 0);
        chk("t6_grant", 32'(grant_id), 0);
        chk("t6_ptr", m_ptr, 0);
        glog.delete();
        for (int b = 0; b < 3; b++) begin
            push(0, 'hD0 + b, 1);
            push(2, 'hE0 + b, 1);
        end
        for (k = 0; k < 40 && !all_empty(); k++) cyc(1);
        cyc(2);
        chk("t6_ngrant", glog.size(), 6);
        for (int i = 0; i < 6; i++) chk($sformatf("t6_grant%0d", i), glog[i], exp_g6[i]);
        chk("t6_level_end", 32'(level), 6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/ehgu_fifo_arb.md
Name: ehgu_fifo_arb

Overview:
- Round-robin write-side scheduler that shares one ehgu_fifo write port among NREQ requesters.
- Grants one requester at a time for a burst, bounded by req_last or MAX_BURST beats.
- Registers the winning beat onto the FIFO write interface.
- Tracks FIFO occupancy with a credit counter, so writes never overflow and pops never underflow.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, data width per beat.
- DEPTH, 32, FIFO capacity in entries; level counter is $clog2(DEPTH)+1 bits.
- MAX_BURST, 4, maximum beats per grant before forced rotation (1..16).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester beat valid.
- req_last  in  NREQ  per-requester last beat of burst.
- req_data  in  NREQ*WIDTH  requester i occupies bits [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  per-requester beat accepted this cycle.
- fifo_wr_en  out  1  registered write strobe to FIFO.
- fifo_wr_data  out  WIDTH  registered write data.
- fifo_wr_src  out  $clog2(NREQ)  registered source id of the written beat.
- fifo_rd_en  in  1  consumer pop of one FIFO entry.
- level  out  $clog2(DEPTH)+1  current occupancy.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- grant_id  out  $clog2(NREQ)  current or last granted requester.

Behaviour:
- Reset (rst high at posedge):
  - state=IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, level=0.
  - fifo_wr_en=0, fifo_wr_data=0, fifo_wr_src=0.
  - req_ready=0, full=0, empty=1.
  - Reset mid-burst drops the burst; no write is issued in the reset cycle.
- States: IDLE, GRANT.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NREQ.
  - First hit j: grant_id<=j, beat_cnt<=0, ->GRANT next cycle. No beat accepted in the arbitration cycle.
  - No request: stay in IDLE.
- GRANT:
  - req_ready[grant_id] = !full_next_free, where full_next_free = (level==DEPTH). Combinational; all other req_ready bits are 0.
  - Accept = req_valid[grant_id] & req_ready[grant_id].
  - On accept: fifo_wr_en<=1, fifo_wr_data<=beat, fifo_wr_src<=grant_id (1-cycle latency); beat_cnt++.
  - Burst end = accept & (req_last[grant_id] | beat_cnt==MAX_BURST-1).
  - On burst end: rr_ptr<=grant_id+1 (mod NREQ), ->IDLE.
  - Valid deasserted mid-burst: hold grant, no rotation (requester owns the port until last or MAX_BURST).
  - When full: ready=0, grant held, resume when a pop frees space.
- Credit counter:
  - level_next = level + accept - (fifo_rd_en & !empty).
  - Pop when empty is ignored.
  - Simultaneous accept+pop: level unchanged.
  - Accept is counted in the accept cycle, one cycle before fifo_wr_en.
  - full/empty are registered from level_next.
- Back-to-back bursts cost 1 idle arbitration cycle.
- Maximum throughput: MAX_BURST beats per MAX_BURST+1 cycles.

Optional Feature:
- Macro: EHGU_FIFO_ARB_PRIO_EN.
- Defined:
  - Requester 0 is fixed high priority: in IDLE, if req_valid[0] it wins regardless of rr_ptr.
  - rr_ptr is not updated after a requester-0 burst.
  - Requesters 1..NREQ-1 rotate round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters.

Test Plan:
- Single requester: reset, req 2 sends 3 beats 0x11,0x22,0x33 (last on 3rd), no pops.
  - fifo_wr_en pulses 3 cycles, each 1 cycle after accept.
  - fifo_wr_src=2; level goes 0->3; empty=0.
  - rr_ptr=3 afterwards.
- Round-robin: all 4 requesters valid continuously, last on every beat, pops every cycle.
  - Grant order 0,1,2,3,0,1.
  - Each burst 1 beat with 1 idle cycle between; level stays ≤1.
- MAX_BURST cut: req 1 streams 10 beats, never asserts last; req 0 also valid.
  - After 4 accepts the grant rotates away from 1.
  - Req 1 is regranted only after others are served.
- Full boundary: fill 32 beats with no pops.
  - full=1, req_ready=0, level=32.
  - Assert fifo_rd_en 1 cycle: level 31, next beat accepted, level back to 32.
  - Simultaneous accept+pop at level 31 leaves level 31.
- Empty underflow: level=0, fifo_rd_en held 5 cycles -> level stays 0, empty=1.
- Reset mid-burst: req 3 at beat 2 of 4, assert rst 1 cycle.
  - Next cycle level=0, state IDLE, fifo_wr_en=0, rr_ptr=0.
  - With EHGU_FIFO_ARB_PRIO_EN: req 0 and req 2 both valid -> req 0 granted first every time.
